// File: rtl/bool_unit_arbiter.sv
// Round-robin arbiter granting N_REQ requesters access to one shared
// single-bit Boolean unit (AND/OR/XOR/NAND). One operation per 3 cycles.
module bool_unit_arbiter #(
    parameter int unsigned N_REQ = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req,
    input  logic [2*N_REQ-1:0]         op,
    input  logic [N_REQ-1:0]           a,
    input  logic [N_REQ-1:0]           b,
    output logic [N_REQ-1:0]           gnt,
    output logic [N_REQ-1:0]           done,
    output logic                       y,
    output logic [$clog2(N_REQ)-1:0]   gnt_id,
    output logic                       busy,
    output logic [7:0]                 ops_done
);

    localparam int unsigned ID_W  = $clog2(N_REQ);
    localparam int unsigned IDX_W = ID_W + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   rr_ptr_nxt;
    logic [1:0]        op_q;
    logic [1:0]        op_nxt;
    logic              a_q;
    logic              a_nxt;
    logic              b_q;
    logic              b_nxt;
    logic [N_REQ-1:0]  gnt_nxt;
    logic [N_REQ-1:0]  done_nxt;
    logic              y_nxt;
    logic [ID_W-1:0]   gnt_id_nxt;
    logic              busy_nxt;
    logic [7:0]        ops_done_nxt;

    logic              win_found;
    logic [ID_W-1:0]   win_id;
    logic [IDX_W-1:0]  idx;
    logic              result;

    // Round-robin search: first requester at or above rr_ptr, wrapping to 0
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        idx       = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            idx = {1'b0, rr_ptr} + IDX_W'(i);
            if (idx >= IDX_W'(N_REQ)) begin
                idx = idx - IDX_W'(N_REQ);
            end
            if (!win_found && req[idx[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = idx[ID_W-1:0];
            end
        end
    end

    // Shared Boolean unit operating on the latched operands
    always_comb begin
        case (op_q)
            2'b00:   result = a_q & b_q;
            2'b01:   result = a_q | b_q;
            2'b10:   result = a_q ^ b_q;
            default: result = ~(a_q & b_q);
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: arbitrate only from IDLE, then walk EXEC -> RESP -> IDLE
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = win_found ? EXEC : IDLE;
            EXEC:    state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic: next values of every registered output and operand latch
    always_comb begin
        rr_ptr_nxt   = rr_ptr;
        op_nxt       = op_q;
        a_nxt        = a_q;
        b_nxt        = b_q;
        gnt_nxt      = gnt;
        done_nxt     = done;
        y_nxt        = y;
        gnt_id_nxt   = gnt_id;
        ops_done_nxt = ops_done;
        busy_nxt     = (state_nxt != IDLE);
        case (state)
            IDLE: begin
                if (win_found) begin
                    gnt_id_nxt = win_id;
                    gnt_nxt    = N_REQ'(1) << win_id;
                    op_nxt     = op[{win_id, 1'b0} +: 2];
                    a_nxt      = a[win_id];
                    b_nxt      = b[win_id];
                end
            end
            EXEC: begin
                y_nxt    = result;
                done_nxt = N_REQ'(1) << gnt_id;
            end
            RESP: begin
                done_nxt     = '0;
                gnt_nxt      = '0;
                rr_ptr_nxt   = (gnt_id == ID_W'(N_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
                ops_done_nxt = ops_done + 8'd1;
            end
            default: begin
                done_nxt = '0;
                gnt_nxt  = '0;
            end
        endcase
    end

    // Output and operand registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= '0;
            op_q     <= '0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            gnt      <= '0;
            done     <= '0;
            y        <= 1'b0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            ops_done <= '0;
        end else begin
            rr_ptr   <= rr_ptr_nxt;
            op_q     <= op_nxt;
            a_q      <= a_nxt;
            b_q      <= b_nxt;
            gnt      <= gnt_nxt;
            done     <= done_nxt;
            y        <= y_nxt;
            gnt_id   <= gnt_id_nxt;
            busy     <= busy_nxt;
            ops_done <= ops_done_nxt;
        end
    end

endmodule
